uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Memory-mapped UART transmit controller that owns the SOC's `TXD` pin. The CPU's IO bus writes bytes into an internal FIFO. A baud-timed state machine serializes each byte as 8N1 frames and exposes FIFO and overflow status for polling. It sits between the processor's IO decode and the top-level `TXD` output, in the same IO space as the `LEDS` register.

## Interface
- `CLKS_PER_BIT`, 104, number of `CLK` cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 8, number of byte entries; must be a power of 2 and ≥ 2.
- `CLK`  in  1  single system clock; all state updates on its rising edge.
- `RESET`  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- `io_wr`  in  1  write strobe; sampled on one cycle per access.
- `io_rd`  in  1  read strobe.
- `io_addr`  in  2  word select: 0 = DATA, 1 = STATUS; 2 and 3 are reserved.
- `io_wdata`  in  32  write data.
- `io_rdata`  out  32  registered read data.
- `TXD`  out  1  serial line; idles high.
- `tx_idle`  out  1  1 when the FIFO is empty and the FSM is in IDLE.

## Operation
- **DATA write** (`io_wr` with addr 0):
  - Pushes `io_wdata[7:0]` into the FIFO.
  - If the FIFO is full before the edge, the byte is dropped and sticky `ovf` is set. This holds even if a pop happens on the same edge.
- **STATUS write** (`io_wr` with addr 1): `io_wdata[2]`=1 clears `ovf`; all other bits are ignored.
- **STATUS read** (`io_rd` with addr 1): `io_rdata` = {`count`[7:4], `ovf`[2], `empty`[1], `full`[0]}, zero-extended.
  - `count` saturates at 15 if `FIFO_DEPTH` > 15.
- **DATA read and reserved addresses**: `io_rd` returns 0. Writes to reserved addresses are ignored.
- **Simultaneous `io_wr` and `io_rd`**: both take effect; the read returns pre-edge status.
- **FSM states**:
  - IDLE: `TXD`=1. If the FIFO is non-empty, pop into shifter → START.
  - START: `TXD`=0 for `CLKS_PER_BIT` cycles → DATA.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles; 3-bit index → STOP after bit 7.
  - STOP: `TXD`=1 for `CLKS_PER_BIT` cycles. On the last stop cycle: if the FIFO is non-empty, pop → START directly (no idle cycle); else → IDLE.
- **Baud counter**: counts `CLKS_PER_BIT`-1 down to 0; the state/bit advances when it reaches 0. It reloads on every state or bit advance.
- **Reset values**: `TXD`=1, `io_rdata`=0, `tx_idle`=1, FSM=IDLE, FIFO empty, `ovf`=0.
- **Reset mid-frame**: the frame is abandoned, `TXD` goes high asynchronously, and the FIFO contents are discarded.

## Timing
- Write on edge N into an empty FIFO with FSM in IDLE: pop on edge N+1, `TXD` low from N+1.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles.
- Back-to-back frames have zero gap.
- `io_rdata` is valid in the cycle after the `io_rd` edge and holds until the next read.
- `tx_idle` is registered.
  - Falls on the edge after the push into an idle controller.
  - Rises on the edge that returns the FSM to IDLE with the FIFO empty.
- `TXD` is driven from a flop; no combinational path from the inputs.

## Structure
- Package `io_pkg` holds:
  - address constants `UART_DATA_ADDR`=0 and `UART_STATUS_ADDR`=1;
  - status bit indices `ST_FULL`=0, `ST_EMPTY`=1, `ST_OVF`=2, `ST_COUNT_LSB`=4;
  - the FSM state enum {IDLE, START, DATA, STOP}.
- Sub-module `sync_fifo`:
  - parameters: width 8, depth `FIFO_DEPTH`;
  - read/write pointers one bit wider than the address, giving full/empty and count;
  - async active-low reset; pointers wrap at `FIFO_DEPTH`.
- Top level contains the register decode, `ovf`, the baud counter, the shifter and the FSM.

## Test plan
- **Single byte**: `CLKS_PER_BIT`=4, write 0x55 → `TXD`: start 0 for 4 cycles, bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop 1 for 4 cycles. `tx_idle` high again 41 cycles after the write.
- **Back-to-back**: write 0x01, 0x02, 0x03 on consecutive cycles → three frames, 120 cycles total, no idle gap. STATUS read mid-run shows `count` decrementing.
- **Overflow**: `FIFO_DEPTH`=8. Write 10 bytes in consecutive cycles while the first frame is in progress:
  - first byte popped at once; next 8 fill the FIFO; 10th dropped;
  - STATUS reads `full`=1 and `ovf`=1;
  - 9 bytes are transmitted in order;
  - writing STATUS with 0x4 clears `ovf`.
- **Reset mid-frame**: assert `RESET`=0 during bit 3 with 2 bytes queued → `TXD`=1 immediately. After release, STATUS = 0x2 (empty) and no further frames are sent.
- **Reserved access**: read addr 2 → `io_rdata`=0. Write addr 3 → FIFO and `ovf` unchanged.
- **Wrap-around**: send 20 bytes 0x00–0x13 in bursts of 5 → all received in order via a bench UART monitor; pointers wrap at least twice.

Source files
------------

// File: rtl/io_pkg.sv
// Shared IO-space definitions for the UART transmit controller: register
// addresses, STATUS bit positions, transmitter states and the STATUS packer.
package io_pkg;

    localparam logic [1:0] UART_DATA_ADDR   = 2'd0;
    localparam logic [1:0] UART_STATUS_ADDR = 2'd1;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] pack_status(
        input logic [3:0] count,
        input logic       ovf,
        input logic       empty,
        input logic       full
    );
        logic [31:0] st;
        st                      = 32'd0;
        st[ST_COUNT_LSB +: 4]   = count;
        st[ST_OVF]              = ovf;
        st[ST_EMPTY]            = empty;
        st[ST_FULL]             = full;
        return st;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; the head entry is presented on
// dout so a pop and the consumer's capture happen on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty  = (wr_ptr_r == rd_ptr_r);
    assign count  = wr_ptr_r - rd_ptr_r;
    assign push_s = wr_en && !full;
    assign pop_s  = rd_en && !empty;
    assign dout   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are meaningless once the pointers reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter: IO register decode, sticky overflow flag,
// byte FIFO and a baud-timed 8N1 serializer driving the TXD pin.
module uart_tx_ctrl
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [1:0]  io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        TXD,
    output logic        tx_idle
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int BW  = $clog2(CLKS_PER_BIT);
    localparam int CNT_MAX = 15;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE    = BW'(1);
    localparam logic [BW-1:0] BAUD_ZERO   = BW'(0);

    tx_state_e       state_r;
    logic [BW-1:0]   baud_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            txd_r;
    logic            tx_idle_r;
    logic            ovf_r;
    logic [31:0]     rdata_r;

    logic            wr_data_s;
    logic            wr_status_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    logic [7:0]      fifo_dout_s;
    logic            baud_zero_s;
    logic            launch_s;
    logic            pop_s;
    logic [3:0]      count_sat_s;
    logic [31:0]     status_s;
    logic            unused_s;

    assign wr_data_s   = io_wr && (io_addr == UART_DATA_ADDR);
    assign wr_status_s = io_wr && (io_addr == UART_STATUS_ADDR);
    assign baud_zero_s = (baud_r == BAUD_ZERO);
    // A new frame may begin from IDLE or on the final stop-bit cycle
    assign launch_s    = (state_r == IDLE) || ((state_r == STOP) && baud_zero_s);
    assign pop_s       = launch_s && !fifo_empty_s;
    assign status_s    = pack_status(count_sat_s, ovf_r, fifo_empty_s, fifo_full_s);
    assign unused_s    = ^{io_wdata[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .wr_en (wr_data_s),
        .din   (io_wdata[7:0]),
        .rd_en (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // STATUS count field saturates for FIFOs deeper than 15 entries
    always_comb begin
        count_sat_s = 4'd0;
        if (int'(fifo_count_s) > CNT_MAX) begin
            count_sat_s = 4'd15;
        end else begin
            count_sat_s = 4'(fifo_count_s);
        end
    end

    // Register file: sticky overflow and registered read data
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ovf_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            if (wr_data_s && fifo_full_s) begin
                ovf_r <= 1'b1;
            end else if (wr_status_s && io_wdata[ST_OVF]) begin
                ovf_r <= 1'b0;
            end
            if (io_rd) begin
                rdata_r <= (io_addr == UART_STATUS_ADDR) ? status_s : 32'd0;
            end
        end
    end

    // Serializer FSM with baud counter, shifter, TXD and idle flag
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r   <= IDLE;
            baud_r    <= BAUD_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            txd_r     <= 1'b1;
            tx_idle_r <= 1'b1;
        end else begin
            tx_idle_r <= launch_s && fifo_empty_s;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        shift_r <= fifo_dout_s;
                        baud_r  <= BAUD_RELOAD;
                        txd_r   <= 1'b0;
                        state_r <= START;
                    end else begin
                        txd_r   <= 1'b1;
                    end
                end
                START: begin
                    if (baud_zero_s) begin
                        baud_r    <= BAUD_RELOAD;
                        bit_idx_r <= 3'd0;
                        txd_r     <= shift_r[0];
                        state_r   <= DATA;
                    end else begin
                        baud_r    <= baud_r - BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_zero_s) begin
                        baud_r <= BAUD_RELOAD;
                        if (bit_idx_r == 3'd7) begin
                            txd_r   <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r - BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_zero_s) begin
                        if (pop_s) begin
                            shift_r <= fifo_dout_s;
                            baud_r  <= BAUD_RELOAD;
                            txd_r   <= 1'b0;
                            state_r <= START;
                        end else begin
                            txd_r   <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        baud_r <= baud_r - BAUD_ONE;
                    end
                end
                default: begin
                    txd_r   <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign TXD      = txd_r;
    assign tx_idle  = tx_idle_r;
    assign io_rdata = rdata_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl against a frame-timeline/queue reference
// model, with a TXD line decoder collecting the received bytes.
module tb_uart_tx_ctrl;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic        clk;
    logic        rst_n;
    logic        io_wr;
    logic        io_rd;
    logic [1:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        txd;
    logic        tx_idle;

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .io_wr    (io_wr),
        .io_rd    (io_rd),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .TXD      (txd),
        .tx_idle  (tx_idle)
    );

    always #5 clk = ~clk;

    int          total;
    int          bad;

    // reference model: queue of pending bytes, cycles left in current frame
    logic [7:0]  q[$];
    logic [7:0]  sent[$];
    logic [7:0]  recv[$];
    int          tx_rem;
    logic [7:0]  cur_byte;
    logic        m_ovf;
    logic [31:0] exp_rdata;
    logic        exp_idle;

    // line decoder state
    bit          mon_busy;
    int          mon_c;
    logic [9:0]  mon_bits;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        int n;
        logic [31:0] s;
        n = q.size();
        s = 32'd0;
        s[7:4] = (n > 15) ? 4'd15 : 4'(n);
        s[2] = m_ovf;
        s[1] = (n == 0);
        s[0] = (n == DEPTH);
        return s;
    endfunction

    function automatic logic exp_txd();
        int slot;
        if (tx_rem == 0) return 1'b1;
        slot = (FRAME - tx_rem) / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return cur_byte[slot-1];
    endfunction

    task automatic monitor_step();
        if (!mon_busy) begin
            if (txd == 1'b0) begin
                mon_busy = 1'b1;
                mon_c    = 0;
            end
        end else begin
            mon_c++;
        end
        if (mon_busy) begin
            if (mon_c % CPB == CPB / 2) mon_bits[mon_c / CPB] = txd;
            if (mon_c == FRAME - 1) begin
                mon_busy = 1'b0;
                check_val("frame_bits", {30'd0, mon_bits[9], mon_bits[0]}, 32'd2);
                recv.push_back(mon_bits[8:1]);
            end
        end
    endtask

    // one clock cycle: drive, advance model on the edge, check after the edge
    task automatic cycle(input logic wr, input logic rd, input logic [1:0] addr, input logic [31:0] wdata);
        logic [31:0] st;
        bit          pre_empty;
        bit          pre_full;
        io_wr = wr; io_rd = rd; io_addr = addr; io_wdata = wdata;
        st = model_status();
        pre_empty = (q.size() == 0);
        pre_full  = (q.size() == DEPTH);
        @(posedge clk);
        if (rd) exp_rdata = (addr == 2'd1) ? st : 32'd0;
        if (tx_rem <= 1 && !pre_empty) begin
            cur_byte = q.pop_front();
            sent.push_back(cur_byte);
            tx_rem = FRAME;
        end else if (tx_rem > 0) begin
            tx_rem--;
        end
        if (wr && addr == 2'd0) begin
            if (pre_full) m_ovf = 1'b1;
            else q.push_back(wdata[7:0]);
        end
        if (wr && addr == 2'd1 && wdata[2]) m_ovf = 1'b0;
        exp_idle = (tx_rem == 0) && pre_empty;
        #1;
        check_val("txd", {31'd0, txd}, {31'd0, exp_txd()});
        check_val("tx_idle", {31'd0, tx_idle}, {31'd0, exp_idle});
        check_val("rdata", io_rdata, exp_rdata);
        io_wr = 1'b0; io_rd = 1'b0;
        monitor_step();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && !(tx_rem == 0 && q.size() == 0); i++)
            cycle(1'b0, 1'b0, 2'd0, 32'd0);
        idle_cycles(2);
    endtask

    task automatic compare_rx(input string tag);
        int n;
        check_val({tag, "_count"}, recv.size(), sent.size());
        n = (recv.size() < sent.size()) ? recv.size() : sent.size();
        for (int i = 0; i < n; i++) check_val({tag, "_byte"}, {24'd0, recv[i]}, {24'd0, sent[i]});
        recv.delete();
        sent.delete();
    endtask

    initial begin
        total = 0; bad = 0;
        clk = 1'b0; rst_n = 1'b0;
        io_wr = 1'b0; io_rd = 1'b0; io_addr = 2'd0; io_wdata = 32'd0;
        tx_rem = 0; cur_byte = 8'd0; m_ovf = 1'b0; exp_rdata = 32'd0; exp_idle = 1'b1;
        mon_busy = 1'b0; mon_c = 0; mon_bits = 10'd0;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset_txd", {31'd0, txd}, 32'd1);
        check_val("reset_idle", {31'd0, tx_idle}, 32'd1);
        check_val("reset_rdata", io_rdata, 32'd0);
        rst_n = 1'b1;

        // single byte
        cycle(1'b1, 1'b0, 2'd0, 32'h55);
        idle_cycles(45);
        check_val("single_idle", {31'd0, tx_idle}, 32'd1);
        compare_rx("single");

        // back-to-back with mid-run status reads
        cycle(1'b1, 1'b0, 2'd0, 32'h01);
        cycle(1'b1, 1'b0, 2'd0, 32'h02);
        cycle(1'b1, 1'b0, 2'd0, 32'h03);
        cycle(1'b0, 1'b1, 2'd1, 32'd0);
        idle_cycles(40);
        cycle(1'b0, 1'b1, 2'd1, 32'd0);
        drain();
        compare_rx("b2b");

        // overflow
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 2'd0, 32'(8'hA0 + i));
        cycle(1'b0, 1'b1, 2'd1, 32'd0);
        check_val("ovf_status", io_rdata, 32'h85);
        cycle(1'b1, 1'b0, 2'd1, 32'h4);
        cycle(1'b0, 1'b1, 2'd1, 32'd0);
        check_val("ovf_clear", io_rdata, 32'h81);
        drain();
        check_val("ovf_rx_count", recv.size(), 32'd9);
        compare_rx("ovf");

        // reserved accesses
        cycle(1'b1, 1'b0, 2'd3, 32'hFF);
        cycle(1'b0, 1'b1, 2'd2, 32'd0);
        check_val("rsvd_read", io_rdata, 32'd0);
        cycle(1'b0, 1'b1, 2'd1, 32'd0);
        check_val("rsvd_status", io_rdata, 32'h2);
        cycle(1'b0, 1'b1, 2'd0, 32'd0);
        check_val("data_read", io_rdata, 32'd0);

        // reset during data bit 3 with two bytes queued
        cycle(1'b1, 1'b0, 2'd0, 32'h3C);
        cycle(1'b1, 1'b0, 2'd0, 32'h5A);
        cycle(1'b1, 1'b0, 2'd0, 32'h96);
        idle_cycles(16);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_txd", {31'd0, txd}, 32'd1);
        check_val("rst_idle", {31'd0, tx_idle}, 32'd1);
        check_val("rst_rdata", io_rdata, 32'd0);
        if (tx_rem > 0) void'(sent.pop_back());
        q.delete(); tx_rem = 0; m_ovf = 1'b0; exp_rdata = 32'd0; mon_busy = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        cycle(1'b0, 1'b1, 2'd1, 32'd0);
        check_val("rst_status", io_rdata, 32'h2);
        idle_cycles(60);
        compare_rx("rst");

        // wrap-around: 20 bytes in bursts of 5
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 2'd0, 32'(b * 5 + i));
            drain();
        end
        check_val("wrap_rx_count", recv.size(), 32'd20);
        compare_rx("wrap");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic       w;
            logic       r;
            logic [1:0] a;
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            cycle(w, r, a, $urandom);
        end
        drain();
        compare_rx("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
